// File: rtl/move_input_conditioner.sv
// Maze-game input stage: synchronises and debounces four direction buttons, generates move_clk,
// and registers mutually exclusive Up/Down/Left/Right levels. Define MOVE_ONESHOT_EN for one step per press.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_PERIOD     = 1000000
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic       Up,
  output logic       Down,
  output logic       Left,
  output logic       Right,
  output logic       move_clk,
  output logic [3:0] btn_db
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int MW = $clog2(MOVE_PERIOD);
  // Acceptance happens on the increment that would take the counter to DEBOUNCE_CYCLES-1
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [MW-1:0] MCNT_LAST = MW'(MOVE_PERIOD - 1);
  localparam logic [MW-1:0] MCNT_HALF = MW'(MOVE_PERIOD / 2);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;

  // Every 4-bit button vector is ordered {R,L,U,D}
  logic [3:0]    raw;
  logic [3:0]    sync_a;
  logic [3:0]    sync;
  db_state_t     db_state    [4];
  db_state_t     db_state_nx [4];
  logic [DW-1:0] db_cnt      [4];
  logic [DW-1:0] db_cnt_nx   [4];
  logic [3:0]    btn_db_nx;
  logic [MW-1:0] mcnt;
  logic          load;
  logic [3:0]    win;
  logic [3:0]    dir;

  assign raw = {BtnR, BtnL, BtnU, BtnD};

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_a <= '0;
      sync   <= '0;
    end else begin
      sync_a <= raw;
      sync   <= sync_a;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_state_nx[i] = db_state[i];
      db_cnt_nx[i]   = db_cnt[i];
      btn_db_nx[i]   = btn_db[i];
      unique case (db_state[i])
        STABLE_LO: if (sync[i]) begin
          db_state_nx[i] = WAIT_HI;
          db_cnt_nx[i]   = '0;
        end
        WAIT_HI: begin
          if (!sync[i]) db_state_nx[i] = STABLE_LO;
          else if (db_cnt[i] == DB_LAST) begin
            db_state_nx[i] = STABLE_HI;
            btn_db_nx[i]   = 1'b1;
          end else db_cnt_nx[i] = db_cnt[i] + DW'(1);
        end
        STABLE_HI: if (!sync[i]) begin
          db_state_nx[i] = WAIT_LO;
          db_cnt_nx[i]   = '0;
        end
        WAIT_LO: begin
          if (sync[i]) db_state_nx[i] = STABLE_HI;
          else if (db_cnt[i] == DB_LAST) begin
            db_state_nx[i] = STABLE_LO;
            btn_db_nx[i]   = 1'b0;
          end else db_cnt_nx[i] = db_cnt[i] + DW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        db_state[i] <= STABLE_LO;
        db_cnt[i]   <= '0;
      end
      btn_db <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        db_state[i] <= db_state_nx[i];
        db_cnt[i]   <= db_cnt_nx[i];
      end
      btn_db <= btn_db_nx;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mcnt     <= '0;
      move_clk <= 1'b0;
    end else begin
      mcnt     <= (mcnt == MCNT_LAST) ? '0 : mcnt + MW'(1);
      move_clk <= (mcnt >= MCNT_HALF);
    end
  end

  // Fixed priority Right > Left > Up > Down; result is one-hot or zero
  function automatic logic [3:0] pick(input logic [3:0] req);
    logic [3:0] g;
    g = 4'b0000;
    if (req[3])      g = 4'b1000;
    else if (req[2]) g = 4'b0100;
    else if (req[1]) g = 4'b0010;
    else if (req[0]) g = 4'b0001;
    return g;
  endfunction

  assign load = (mcnt == '0);

`ifdef MOVE_ONESHOT_EN
  logic [3:0] armed;
  logic [3:0] released;

  assign released = btn_db & ~btn_db_nx;
  assign win      = pick(btn_db & armed);

  // A release re-arms even if the same edge consumed the button at a load point
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) armed <= 4'b1111;
    else          armed <= (armed & ~(load ? win : 4'b0000)) | released;
  end
`else
  assign win = pick(btn_db);
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)  dir <= '0;
    else if (load) dir <= win;
  end

  assign Right = dir[3];
  assign Left  = dir[2];
  assign Up    = dir[1];
  assign Down  = dir[0];
endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Front-end input stage for the maze game. Turns the four raw, bouncing direction push-buttons into clean, mutually exclusive `Up`/`Down`/`Left`/`Right` levels, and generates the slow `move_clk` that drives the block-movement state machine. Direction levels change only while `move_clk` is low, so the downstream stage always samples stable values on the `move_clk` rising edge.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: `clk` cycles a synchronised button must hold a new level before it is accepted. Minimum 2.
- `MOVE_PERIOD`, default 1000000: `clk` cycles per `move_clk` period. Must be even and at least 4.
- `clk` input 1: system clock. All logic runs on its rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `BtnU`, `BtnD`, `BtnL`, `BtnR` input 1 each: raw asynchronous button levels, active high.
- `Up`, `Down`, `Left`, `Right` output 1 each: registered direction requests. At most one is high.
- `move_clk` output 1: registered 50% duty movement clock.
- `btn_db` output 4: debounced button levels {R,L,U,D}, registered.

## Operation
- Synchroniser: each raw button passes through 2 flops. `sync` is the second flop.
- Debounce: a 4-state FSM per button, sharing no counters.
  - `STABLE_LO` goes to `WAIT_HI` when `sync` is 1. The counter clears.
  - `WAIT_HI` increments while `sync` is 1. If `sync` returns to 0, go back to `STABLE_LO`. When the counter reaches `DEBOUNCE_CYCLES-1`, go to `STABLE_HI` and set `btn_db` bit to 1.
  - `STABLE_HI` and `WAIT_LO` behave symmetrically for release.
- Move timer: counter `mcnt` runs 0..`MOVE_PERIOD-1` and wraps to 0.
  - `move_clk` is 0 while `mcnt < MOVE_PERIOD/2`, otherwise 1. It is registered, so it follows `mcnt` by one cycle.
- Direction load: on the cycle where `mcnt == 0`, the direction outputs load from `btn_db` using fixed priority Right > Left > Up > Down. The result is one-hot or all zero.
  - Outputs hold between load points.
- Simultaneous presses resolve by priority only. There is no memory of press order.
- A button that bounces shorter than `DEBOUNCE_CYCLES` never changes `btn_db` or any direction output.
- Reset, including mid-operation: all FSMs go to `STABLE_LO`, counters clear, synchroniser flops clear. `btn_db`=0, all directions=0, `move_clk`=0, `mcnt`=0.
- After reset release, the first load happens at the first `mcnt==0` cycle, which is the first `clk` edge after `Reset_n` rises.

## Timing
- Press to `btn_db` latency: 2 cycles (sync) + `DEBOUNCE_CYCLES` cycles.
- `btn_db` to direction latency: 1 to `MOVE_PERIOD` cycles, waiting for the next `mcnt==0`.
- Direction outputs change only in the cycle that `move_clk` is driven low, or one cycle before it. They are always stable for the full high half plus at least `MOVE_PERIOD/2-1` cycles before each rising edge.
- `move_clk` first rises `MOVE_PERIOD/2+1` cycles after reset release.
- All outputs come straight from flops. No combinational path exists from inputs to outputs.

## Configuration
- `MOVE_ONESHOT_EN` defined: one step per press.
  - Each direction has an `armed` flag. It is set at reset and on that button's debounced release.
  - At a load point, the winner is chosen by priority from buttons that are both pressed and armed. The winner's flag clears.
  - The direction is asserted for exactly one `MOVE_PERIOD`, then drops to 0 while the button stays held.
- `MOVE_ONESHOT_EN` undefined: auto-repeat. A held button asserts its direction at every load point, one step per `move_clk` period. No `armed` logic is built.

## Test plan
Directed tests use `DEBOUNCE_CYCLES`=4 and `MOVE_PERIOD`=8.
- **Reset:** pulse `Reset_n` low mid-period while `BtnR` is held. Required: all outputs are 0 the same cycle, asynchronously. `move_clk` rises 5 cycles after release.
- **Glitch rejection:** a 3-cycle pulse on `BtnU`. Required: `btn_db` stays 0 and `Up` never asserts.
- **Clean press:** hold `BtnL`. Required: `btn_db[2]`=1 six cycles after the edge. `Left`=1 at the next `mcnt==0` and stays high across every following `move_clk` rise while held (repeat build).
- **Priority:** hold `BtnD`, `BtnU` and `BtnR` together. Required: only `Right`=1. Release `BtnR`: `Up`=1 from the next load point; `Down` stays 0.
- **One-shot** (`MOVE_ONESHOT_EN` defined): hold `BtnU` for 40 cycles. Required: `Up`=1 for exactly 8 cycles (one load period), then 0. Release and press again: exactly one more 8-cycle pulse.
- **Stability check:** sweep presses at random phases. Required: no direction output ever changes while `move_clk`=1, and at most one direction is high at any time.
